// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter driving a shared 4:1 data path.
//
// Ports:
//   clk   - sole clock, all state updates on the rising edge
//   rst   - synchronous, active-high reset
//   req   - request lines, req[k] high means requester k wants the data path
//   i0-i3 - requester data lines
//   gnt   - registered one-hot grant, zero when idle
//   sel   - registered index of the current owner (holds its value while idle)
//   y     - selected data line, i[sel] while busy, 0 while idle
//   busy  - high while any grant is active (|gnt)
//   tout  - one-cycle pulse when a grant is revoked by the hold timeout
//
// Parameter:
//   MAX_HOLD - maximum consecutive grant cycles per owner (2..255), used only
//              when the timeout feature is compiled in.
//
// Build option:
//   ARB_TIMEOUT_EN - when defined, an 8-bit hold counter revokes a grant after
//                    MAX_HOLD cycles; when undefined, grants are held
//                    indefinitely and tout is tied low.

module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       busy,
    output logic       tout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be within 2..255");
    end

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;

    // High when the owner gives up or loses the grant at this edge.
    logic       release_now;
    logic       revoke_now;
    logic [2:0] pick;
    logic [1:0] next_base;

    // Returns {found, index} of the first set mask bit in the order
    // base, base+1, base+2, base+3 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
        logic [1:0] cand;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            cand = base + 2'(k);
            if (!res[2] && mask[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       tout_q, tout_d;
    logic       hold_expired;

    // Counter starts at 0 on the grant edge, so reaching MAX_HOLD-1 means the
    // owner has seen MAX_HOLD grant cycles by the coming edge.
    assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));
`endif

    assign next_base = sel_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        release_now = 1'b0;
        revoke_now  = 1'b0;
        pick        = 3'b000;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        tout_d      = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d = StGrant;
                    gnt_d   = onehot(pick[1:0]);
                    sel_d   = pick[1:0];
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end

            StGrant: begin
                if (!req[sel_q]) begin
                    release_now = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_expired) begin
                    revoke_now = 1'b1;
                    tout_d     = 1'b1;
                end
`endif

                if (release_now || revoke_now) begin
                    ptr_d = next_base;
                    // The outgoing owner is excluded from this round.
                    pick  = rr_pick(req & ~onehot(sel_q), next_base);
                    if (pick[2]) begin
                        gnt_d = onehot(pick[1:0]);
                        sel_d = pick[1:0];
`ifdef ARB_TIMEOUT_EN
                        hold_d = 8'd0;
`endif
                    end else if (revoke_now) begin
                        // Timed-out owner is the only requester: keep it, restart the count.
`ifdef ARB_TIMEOUT_EN
                        hold_d = 8'd0;
`endif
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            tout_q  <= tout_d;
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign tout = tout_q;
`else
    assign tout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

    logic y_mux;

    always_comb begin
        y_mux = 1'b0;
        case (sel_q)
            2'd0:    y_mux = i0;
            2'd1:    y_mux = i1;
            2'd2:    y_mux = i2;
            default: y_mux = i3;
        endcase
    end

    assign y = busy ? y_mux : 1'b0;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: table of directed vectors plus
// hand-written multi-cycle sequences for the hold-timeout behaviour.

module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       i0, i1, i2, i3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       busy;
    logic       tout;

    int checks;
    int failures;

    rr_arbiter_4 #(
        .MAX_HOLD(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .gnt (gnt),
        .sel (sel),
        .y   (y),
        .busy(busy),
        .tout(tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       y;
        logic       busy;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] d);
        rst = r;
        req = rq;
        i0  = d[0];
        i1  = d[1];
        i2  = d[2];
        i3  = d[3];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gt(input string name, input logic [3:0] g, input logic t);
        check({name, " gnt"}, 8'(gnt), 8'(g));
        check({name, " tout"}, 8'(tout), 8'(t));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 4'b0000, 4'b0000);

        //         rst   req      din      gnt      sel    y     busy
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 4'b1111, 4'b1110, 4'b0001, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 4'b1110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'b0001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b1101, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
        // ptr is now 2: search 2,3,0,1 picks 3, not 1.
        vecs[15] = '{1'b0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 4'b1010, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        // Reset mid-grant, then ptr=0 makes requester 1 win over 3.
        vecs[17] = '{1'b1, 4'b1010, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        for (int k = 0; k < 20; k++) begin
            drive(vecs[k].rst, vecs[k].req, vecs[k].din);
            step();
            check($sformatf("v%0d gnt", k), 8'(gnt), 8'(vecs[k].gnt));
            check($sformatf("v%0d sel", k), 8'(sel), 8'(vecs[k].sel));
            check($sformatf("v%0d y", k), 8'(y), 8'(vecs[k].y));
            check($sformatf("v%0d busy", k), 8'(busy), 8'(vecs[k].busy));
            check($sformatf("v%0d tout", k), 8'(tout), 8'(1'b0));
        end

`ifdef ARB_TIMEOUT_EN
        // req=0011 held: owner 0 for 4 cycles, then revoked in favour of 1.
        drive(1'b0, 4'b0011, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_gt($sformatf("to_a%0d", c), 4'b0001, 1'b0);
        end
        step();
        expect_gt("to_switch", 4'b0010, 1'b1);
        step();
        expect_gt("to_after", 4'b0010, 1'b0);
        // Only requester 0: each timeout re-grants it and pulses tout.
        drive(1'b0, 4'b0001, 4'b0000);
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                expect_gt($sformatf("to_solo%0d_%0d", r, c), 4'b0001, (r == 1 && c == 1));
            end
        end
        step();
        expect_gt("to_solo_pulse", 4'b0001, 1'b1);
        step();
        expect_gt("to_solo_end", 4'b0001, 1'b0);
`else
        // Without the timeout the owner keeps the grant indefinitely.
        drive(1'b0, 4'b0011, 4'b0000);
        for (int c = 1; c <= 12; c++) begin
            step();
            expect_gt($sformatf("hold%0d", c), 4'b0001, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
